// File: rtl/mem_stage.sv
// MEM stage: drives the data-memory req/ack handshake, stalls upstream while an access is in flight,
// and loads the MEM/WB payload. Optional forwarding outputs are enabled by defining MEM_STAGE_FWD_EN.
module mem_stage #(
    parameter int DW = 64,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] ALUresult,
    input  logic [DW-1:0] WriteData,
    input  logic [RW-1:0] Rd,
    input  logic [1:0]    WB,
    input  logic [4:0]    M,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_size,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic [DW-1:0] wb_data_out,
    output logic [RW-1:0] Rd_out,
    output logic          RegWrite_out
`ifdef MEM_STAGE_FWD_EN
    ,
    output logic          fwd_valid,
    output logic [RW-1:0] fwd_Rd,
    output logic [DW-1:0] fwd_data
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic          mem_req_reg,   mem_req_next;
    logic          mem_we_reg,    mem_we_next;
    logic [DW-1:0] mem_addr_reg,  mem_addr_next;
    logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
    logic [1:0]    mem_size_reg,  mem_size_next;
    logic [DW-1:0] load_data_reg, load_data_next;
    logic [DW-1:0] wb_data_reg,   wb_data_next;
    logic [RW-1:0] rd_reg,        rd_next;
    logic          reg_write_reg, reg_write_next;

    logic          memop;
    logic [1:0]    size_code;
    logic [DW-1:0] lane_mask;

    // A write wins when both MemWrite and MemRead are set.
    assign memop     = M[0] | M[1];
    assign size_code = M[4] ? 2'd3 : M[3:2];

    // Byte-lane keep mask for zero-extending load data, driven by the registered size.
    generate
        for (genvar gi = 0; gi < DW / 8; gi++) begin : g_lane
            localparam bit KEEP_B = (gi < 1);
            localparam bit KEEP_H = (gi < 2);
            localparam bit KEEP_W = (gi < 4);
            logic keep;
            always_comb begin
                keep = 1'b1;
                case (mem_size_reg)
                    2'd0:    keep = KEEP_B;
                    2'd1:    keep = KEEP_H;
                    2'd2:    keep = KEEP_W;
                    default: keep = 1'b1;
                endcase
            end
            assign lane_mask[gi*8 +: 8] = {8{keep}};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  state_next = memop ? S_WAIT : S_IDLE;
            S_WAIT:  state_next = mem_ack ? S_DONE : S_WAIT;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic: stall plus next values for the request and MEM/WB registers.
    always_comb begin
        stall          = 1'b0;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_size_next  = mem_size_reg;
        load_data_next = load_data_reg;
        wb_data_next   = '0;
        rd_next        = '0;
        reg_write_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (memop) begin
                    stall          = 1'b1;
                    mem_req_next   = 1'b1;
                    mem_we_next    = M[0];
                    mem_addr_next  = ALUresult;
                    mem_wdata_next = WriteData;
                    mem_size_next  = size_code;
                end else begin
                    wb_data_next   = ALUresult;
                    rd_next        = Rd;
                    reg_write_next = WB[0];
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (mem_ack) begin
                    mem_req_next = 1'b0;
                    if (!mem_we_reg) begin
                        load_data_next = mem_rdata & lane_mask;
                    end
                end
            end
            S_DONE: begin
                wb_data_next   = WB[1] ? load_data_reg : ALUresult;
                rd_next        = Rd;
                reg_write_next = WB[0];
            end
            default: begin
                stall = 1'b0;
            end
        endcase
        // Reset must clear stall immediately, even while upstream still presents a memory op.
        if (rst) begin
            stall = 1'b0;
        end
    end

    // Request and MEM/WB registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_size_reg  <= 2'd0;
            load_data_reg <= '0;
            wb_data_reg   <= '0;
            rd_reg        <= '0;
            reg_write_reg <= 1'b0;
        end else begin
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_size_reg  <= mem_size_next;
            load_data_reg <= load_data_next;
            wb_data_reg   <= wb_data_next;
            rd_reg        <= rd_next;
            reg_write_reg <= reg_write_next;
        end
    end

    assign mem_req      = mem_req_reg;
    assign mem_we       = mem_we_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign mem_size     = mem_size_reg;
    assign wb_data_out  = wb_data_reg;
    assign Rd_out       = rd_reg;
    assign RegWrite_out = reg_write_reg;

`ifdef MEM_STAGE_FWD_EN
    // Register 31 is never a forwarding source.
    assign fwd_valid = reg_write_reg & (rd_reg != RW'(31));
    assign fwd_Rd    = rd_reg;
    assign fwd_data  = wb_data_reg;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage; expected values come from a small transaction-level model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] ALUresult;
    logic [63:0] WriteData;
    logic [4:0]  Rd;
    logic [1:0]  WB;
    logic [4:0]  M;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        stall;
    logic [63:0] wb_data_out;
    logic [4:0]  Rd_out;
    logic        RegWrite_out;
`ifdef MEM_STAGE_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_Rd;
    logic [63:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.DW(64), .RW(5)) dut (
        .clk(clk),
        .rst(rst),
        .ALUresult(ALUresult),
        .WriteData(WriteData),
        .Rd(Rd),
        .WB(WB),
        .M(M),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_size(mem_size),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .stall(stall),
        .wb_data_out(wb_data_out),
        .Rd_out(Rd_out),
        .RegWrite_out(RegWrite_out)
`ifdef MEM_STAGE_FWD_EN
        ,
        .fwd_valid(fwd_valid),
        .fwd_Rd(fwd_Rd),
        .fwd_data(fwd_data)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: zero-extension mask from the size code (4-7 behave as doubleword).
    function automatic logic [63:0] size_mask(input int s);
        if (s >= 3) return '1;
        return (64'd1 << (8 << s)) - 64'd1;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk_fwd(input logic exp_we, input logic [4:0] exp_rd, input logic [63:0] exp_data);
`ifdef MEM_STAGE_FWD_EN
        chk("fwd_valid", fwd_valid, exp_we && (exp_rd != 5'd31));
        chk("fwd_Rd", fwd_Rd, exp_rd);
        chk("fwd_data", fwd_data, exp_data);
`endif
    endtask

    // One instruction presented at posedge+1; returns positioned at posedge+1 just after it retires.
    task automatic run_op(input string name, input logic [63:0] alu, input logic [63:0] wd,
                          input logic [4:0] rd, input logic [1:0] wb, input logic [4:0] m,
                          input logic [63:0] rdata, input int delay, input logic spurious);
        logic        memop;
        logic [63:0] exp_data;
        int          sz;
        int          stall_cycles;
        memop        = m[0] | m[1];
        sz           = int'(m[4:2]);
        stall_cycles = 0;
        ALUresult = alu; WriteData = wd; Rd = rd; WB = wb; M = m;
        mem_ack   = spurious; mem_rdata = rnd64();
        #3;
        chk({name, ".stall_first"}, stall, memop);
        if (stall) stall_cycles++;
        if (!memop) begin
            tick();
            mem_ack = 1'b0;
            exp_data = alu;
        end else begin
            mem_ack = 1'b0;
            tick();
            chk({name, ".req"}, mem_req, 1'b1);
            chk({name, ".we"}, mem_we, m[0]);
            chk({name, ".addr"}, mem_addr, alu);
            chk({name, ".size"}, mem_size, (sz >= 3) ? 2'd3 : 2'(sz));
            if (m[0]) chk({name, ".wdata"}, mem_wdata, wd);
            for (int i = 1; i <= delay; i++) begin
                chk({name, ".wait_stall"}, stall, 1'b1);
                chk({name, ".wait_bubble"}, RegWrite_out, 1'b0);
                chk({name, ".wait_addr"}, mem_addr, alu);
                if (stall) stall_cycles++;
                if (i == delay) begin
                    mem_ack = 1'b1; mem_rdata = rdata;
                end
                tick();
                mem_ack = 1'b0; mem_rdata = rnd64();
                if (i < delay) chk({name, ".req_held"}, mem_req, 1'b1);
            end
            chk({name, ".stall_cycles"}, 64'(stall_cycles), 64'(1 + delay));
            chk({name, ".done_req"}, mem_req, 1'b0);
            chk({name, ".done_stall"}, stall, 1'b0);
            chk({name, ".done_bubble"}, RegWrite_out, 1'b0);
            mem_ack = spurious;
            tick();
            mem_ack = 1'b0;
            exp_data = (!m[0] && wb[1]) ? (rdata & size_mask(sz)) : alu;
        end
        chk({name, ".RegWrite"}, RegWrite_out, wb[0]);
        chk({name, ".Rd"}, Rd_out, rd);
        chk({name, ".wb_data"}, wb_data_out, exp_data);
        chk({name, ".no_req"}, mem_req, 1'b0);
        chk_fwd(wb[0], rd, exp_data);
        $display("op %-8s M=%b WB=%b Rd=%0d alu=%h delay=%0d -> wb=%h we=%b", name, m, wb, rd, alu,
                 delay, wb_data_out, RegWrite_out);
    endtask

    initial begin
        rst = 1'b1;
        ALUresult = '0; WriteData = '0; Rd = '0; WB = '0; M = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.req", mem_req, 1'b0);
        chk("reset.stall", stall, 1'b0);
        chk("reset.wb_data", wb_data_out, 64'd0);
        chk("reset.RegWrite", RegWrite_out, 1'b0);
        chk("reset.Rd", Rd_out, 5'd0);
        rst = 1'b0;

        run_op("alu", 64'h1234, 64'h0, 5'd5, 2'b01, 5'b00000, 64'h0, 0, 1'b1);
        run_op("ld_d", 64'h40, 64'h0, 5'd7, 2'b11, 5'b01110, 64'hDEADBEEF_CAFEF00D, 2, 1'b0);
        run_op("ld_b", 64'h48, 64'h0, 5'd8, 2'b11, 5'b00010, 64'hFFFF_FFFF_FFFF_FF80, 1, 1'b0);
        run_op("st_d", 64'h50, 64'hAA, 5'd9, 2'b00, 5'b01101, 64'h0, 1, 1'b1);
        run_op("ld_w", 64'h58, 64'h0, 5'd10, 2'b11, 5'b01010, 64'h1122_3344_8899_AABB, 3, 1'b1);
        run_op("alu_r31", 64'h77, 64'h0, 5'd31, 2'b01, 5'b00000, 64'h0, 0, 1'b0);

        // Reset in the middle of an outstanding load.
        ALUresult = 64'h60; Rd = 5'd3; WB = 2'b11; M = 5'b01110; mem_ack = 1'b0;
        tick();
        chk("rst_mid.req_before", mem_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid.req", mem_req, 1'b0);
        chk("rst_mid.stall", stall, 1'b0);
        chk("rst_mid.RegWrite", RegWrite_out, 1'b0);
        chk("rst_mid.wb_data", wb_data_out, 64'd0);
        chk("rst_mid.Rd", Rd_out, 5'd0);
        ALUresult = 64'h5; Rd = 5'd0; WB = 2'b00; M = 5'b00000;
        rst = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        mem_ack = 1'b0;
        chk("late_ack.req", mem_req, 1'b0);
        chk("late_ack.stall", stall, 1'b0);
        chk("late_ack.RegWrite", RegWrite_out, 1'b0);
        chk("late_ack.wb_data", wb_data_out, 64'h5);
        $display("op rst_mid  late ack ignored -> wb=%h we=%b", wb_data_out, RegWrite_out);

        // Randomized instruction mix: ALU ops, loads of every size code, stores (sometimes both M bits).
        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [2:0]  sz;
            logic [1:0]  wb;
            logic [4:0]  m;
            kind = int'($urandom_range(0, 2));
            sz   = 3'($urandom_range(0, 7));
            wb   = 2'($urandom_range(0, 3));
            case (kind)
                0: m = 5'b00000;
                1: m = {sz, 2'b10};
                default: begin
                    m  = {sz, 1'($urandom_range(0, 1)), 1'b1};
                    wb = {1'b0, wb[0]};
                end
            endcase
            run_op("rand", rnd64(), rnd64(), 5'($urandom_range(0, 31)), wb, m, rnd64(),
                   int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs in the pipelined CPU.
- Takes the registered ALU result, store data, destination register and M/WB control, and runs a req/ack handshake with the data memory.
- Stalls the pipeline while an access is in flight.
- Drives the MEM/WB payload: register-write data, Rd and RegWrite.

Parameters:
- DW, 64, datapath width of address, store data and load data.
- RW, 5, register-index width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-high
- ALUresult  in  DW  EX/MEM ALU result; also the memory address
- WriteData  in  DW  EX/MEM store data
- Rd  in  RW  EX/MEM destination register
- WB  in  2  [0]=RegWrite, [1]=MemToReg
- M  in  5  [0]=MemWrite, [1]=MemRead, [4:2]=size code (0=B, 1=H, 2=W, 3=D; 4-7 treated as D)
- mem_req  out  1  registered request to data memory
- mem_we  out  1  1=write, 0=read; valid while mem_req
- mem_addr  out  DW  registered address
- mem_wdata  out  DW  registered store data
- mem_size  out  2  registered size code
- mem_ack  in  1  one-cycle completion pulse from memory
- mem_rdata  in  DW  load data, valid with mem_ack
- stall  out  1  hold IF/ID/EX/EX_MEM enables low when 1
- wb_data_out  out  DW  MEM/WB write-back data
- Rd_out  out  RW  MEM/WB destination register
- RegWrite_out  out  1  MEM/WB register write enable

Behaviour:
- Reset values: all outputs 0; FSM in IDLE. Reset mid-access drops mem_req immediately and discards the access; an ack arriving after reset is ignored.
- memop = M[0] | M[1]. If both bits are set, the access is a write and the read is ignored.
- States: IDLE, WAIT, DONE.
- IDLE with !memop:
  - stall=0.
  - At the clock edge, MEM/WB loads wb_data_out=ALUresult, Rd_out=Rd, RegWrite_out=WB[0].
  - Latency is 1 cycle.
- IDLE with memop:
  - stall=1 combinationally in the same cycle.
  - At the edge: go to WAIT; set mem_req=1 and mem_we=M[0]; load mem_addr, mem_wdata and mem_size.
  - MEM/WB loads a bubble (RegWrite_out=0).
- WAIT:
  - stall=1; mem_req held at 1; all request fields held stable.
  - On the edge where mem_ack=1: mem_req goes to 0, go to DONE. For a read, mem_rdata is captured, zero-extended per size (B keeps [7:0], H keeps [15:0], W keeps [31:0], D keeps the full value).
  - MEM/WB loads a bubble every WAIT cycle.
  - No timeout: WAIT persists until ack.
- DONE:
  - stall=0.
  - At the edge, MEM/WB loads Rd_out=Rd and RegWrite_out=WB[0]; wb_data_out = captured load data if WB[1], else ALUresult. Then go to IDLE.
  - EX_MEM advances on this same edge, so the access is never re-issued.
- Minimum memory-op latency: 3 edges (issue, ack, retire) when ack arrives the cycle after req.
- Upstream inputs are stable throughout WAIT/DONE because the EX_MEM enable is low.
- mem_ack outside WAIT is ignored.
- A store (MemWrite) with WB[0]=1 still writes ALUresult, or 0-extended stale data if WB[1]=1. This is the control unit's responsibility; not checked here.

Optional Feature:
- Macro: MEM_STAGE_FWD_EN.
- When defined, add outputs:
  - fwd_valid  out  1
  - fwd_Rd  out  RW
  - fwd_data  out  DW
- These outputs are combinational from the MEM/WB registers: fwd_valid = RegWrite_out & (Rd_out != 31), fwd_Rd = Rd_out, fwd_data = wb_data_out.
- They feed the EX forwarding unit.
- When not defined, these ports do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst mid-WAIT with mem_req=1 -> mem_req, stall and all MEM/WB outputs 0 asynchronously; FSM in IDLE after release; a late mem_ack produces no write-back.
- ALU op: M=0, WB=01, ALUresult=0x1234, Rd=5 -> stall stays 0; next edge RegWrite_out=1, Rd_out=5, wb_data_out=0x1234.
- Load D with 2-cycle ack delay:
  - Stimulus: M=00011 (size=0? no: use M[4:2]=3, M[1]=1), WB=11, ALUresult=0x40, mem_rdata=0xDEADBEEF_CAFEF00D.
  - Response: stall=1 for 3 cycles; mem_req=1, mem_we=0, mem_addr=0x40 until ack; then wb_data_out=0xDEADBEEFCAFEF00D, RegWrite_out=1 one edge after DONE.
- Load byte: size=0, rdata=0xFFFF_FFFF_FFFF_FF80 -> wb_data_out=0x80.
- Store: M[0]=1, M[4:2]=3, WriteData=0xAA, WB=00 -> mem_we=1, mem_wdata=0xAA; RegWrite_out stays 0 throughout; stall releases in DONE.
- Back-to-back load then ALU op: the ALU op is retired exactly one edge after the load retires; no duplicate mem_req pulse. With MEM_STAGE_FWD_EN defined, fwd_valid=0 when Rd_out=31.
